// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction cache address split, frame layout and FSM state.
package cpu_types_pkg;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame_t;

  typedef enum logic {
    IDLE,
    FILL
  } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped frame storage: combinational read, one write port,
// valid bits cleared asynchronously on reset.
module icache_array #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IDX_W-1:0] i_ridx,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag,
  output logic [31:0]      o_data,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic [TAG_W-1:0] i_wtag,
  input  logic [31:0]      i_wdata
);

  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [31:0]      r_data [SETS];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_widx] <= 1'b1;
    end
  end

  // Tag and data carry no reset; valid gates their use.
  always_ff @(posedge CLK) begin
    if (i_we) begin
      r_tag[i_widx]  <= i_wtag;
      r_data[i_widx] <= i_wdata;
    end
  end

  assign o_valid = r_valid[i_ridx];
  assign o_tag   = r_tag[i_ridx];
  assign o_data  = r_data[i_ridx];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with single-word miss fill.
// Optional ICACHE_STATS_EN adds hit_count/miss_count outputs.
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = ICACHE_SETS
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t r_state;
  logic [31:2]   r_miss_addr;

  logic [IDX_W-1:0] w_ridx;
  logic [TAG_W-1:0] w_rtag;
  logic             w_valid;
  logic [TAG_W-1:0] w_tag;
  logic [31:0]      w_data;
  logic             w_match;
  logic             w_start;
  logic             w_we;
  logic             w_unused;

  assign w_ridx   = imemaddr[IDX_W+1:2];
  assign w_rtag   = imemaddr[31:IDX_W+2];
  assign w_unused = &{1'b0, imemaddr[1:0]};

  icache_array #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_ridx  (w_ridx),
    .o_valid (w_valid),
    .o_tag   (w_tag),
    .o_data  (w_data),
    .i_we    (w_we),
    .i_widx  (r_miss_addr[IDX_W+1:2]),
    .i_wtag  (r_miss_addr[31:IDX_W+2]),
    .i_wdata (iload)
  );

  assign w_match  = w_valid && (w_tag == w_rtag);
  assign ihit     = imemREN && (r_state == IDLE) && w_match;
  assign imemload = ihit ? w_data : '0;
  assign w_start  = imemREN && (r_state == IDLE) && !w_match;
  assign w_we     = (r_state == FILL) && !iwait;
  assign iaddr    = {r_miss_addr, 2'b00};

  // Miss address is held only while filling so iaddr reads 0 in IDLE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_miss_addr <= '0;
      iREN        <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state     <= FILL;
            r_miss_addr <= imemaddr[31:2];
            iREN        <= 1'b1;
          end
        end
        FILL: begin
          if (!iwait) begin
            r_state     <= IDLE;
            r_miss_addr <= '0;
            iREN        <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit)    hit_count  <= hit_count + 32'd1;
      if (w_start) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus queues expected hits and fills,
// a negedge monitor pops and compares them.
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = '0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int total = 0;
  int bad   = 0;
  int iren_cyc = 0;
  int wcnt = 0;
  logic [31:0] hitq[$];
  logic [31:0] fillq[$];

  always #5 CLK = ~CLK;

  icache dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    case (a)
      32'h0000_0040: memval = 32'h2001_0005;
      32'h0000_0080: memval = 32'h1234_5678;
      32'h0000_0104: memval = 32'hCAFE_0104;
      32'h0000_0208: memval = 32'hBEEF_0208;
      default:       memval = 32'hDEAD_0000 | a;
    endcase
  endfunction

  // Memory: three busy cycles, then data on the fourth request cycle.
  always @(posedge CLK) begin
    #1;
    if (iREN && wcnt < 3) begin
      iwait = 1'b1;
      wcnt++;
    end else if (iREN) begin
      iwait = 1'b0;
      iload = memval(iaddr);
    end else begin
      iwait = 1'b1;
      wcnt  = 0;
      iload = '0;
    end
  end

  always @(negedge CLK) begin
    if (nRST) begin
      if (iREN) iren_cyc++;
      if (ihit) begin
        if (hitq.size() == 0) chk("unexpected_hit", 32'(ihit), 32'd0);
        else chk("imemload", imemload, hitq.pop_front());
      end else begin
        chk("imemload_nohit", imemload, 32'd0);
      end
      if (iREN && !iwait) begin
        if (fillq.size() == 0) chk("unexpected_fill", iaddr, 32'hFFFF_FFFF);
        else chk("fill_iaddr", iaddr, fillq.pop_front());
      end
      if (!iREN) chk("iaddr_idle", iaddr, 32'd0);
    end
  end

  task automatic fetch(input logic [31:0] a, input logic [31:0] d,
                       input bit miss, input int lat);
    int n;
    int r0;
    n = 0;
    @(posedge CLK);
    #1;
    if (miss) fillq.push_back({a[31:2], 2'b00});
    hitq.push_back(d);
    r0 = iren_cyc;
    imemREN  = 1'b1;
    imemaddr = a;
    forever begin
      @(negedge CLK);
      if (ihit) break;
      n++;
      if (n > 50) break;
    end
    #1;
    if (n > 50) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout: addr %h got no hit want hit", a);
    end else if (lat >= 0) begin
      chk("latency", 32'(n), 32'(lat));
      if (miss) chk("iren_cycles", 32'(iren_cyc - r0), 32'(lat - 1));
    end
  endtask

  initial begin
    nRST     = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk("rst_iREN", 32'(iREN), 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
`ifdef ICACHE_STATS_EN
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
`endif
    imemREN = 1'b0;
    nRST    = 1'b1;

    fetch(32'h40, 32'h2001_0005, 1'b1, 5);
    fetch(32'h42, 32'h2001_0005, 1'b0, 0);
    fetch(32'h80, 32'h1234_5678, 1'b1, 5);
    fetch(32'h40, 32'h2001_0005, 1'b1, 5);

    @(posedge CLK);
    #1;
    fillq.push_back(32'h104);
    imemaddr = 32'h104;
    imemREN  = 1'b1;
    repeat (2) @(negedge CLK);
    chk("squash_iREN", 32'(iREN), 32'd1);
    chk("squash_iaddr", iaddr, 32'h104);
    fetch(32'h208, 32'hBEEF_0208, 1'b1, -1);
    fetch(32'h104, 32'hCAFE_0104, 1'b0, 0);
    fetch(32'h208, 32'hBEEF_0208, 1'b0, 0);

    @(posedge CLK);
    #1;
    imemaddr = 32'h30C;
    imemREN  = 1'b1;
    repeat (2) @(negedge CLK);
    chk("prerst_iREN", 32'(iREN), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("midrst_iREN", 32'(iREN), 32'd0);
    chk("midrst_ihit", 32'(ihit), 32'd0);
    chk("midrst_iaddr", iaddr, 32'd0);
    imemREN = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
`ifdef ICACHE_STATS_EN
    chk("midrst_hit_count", hit_count, 32'd0);
    chk("midrst_miss_count", miss_count, 32'd0);
`endif
    nRST = 1'b1;

    fetch(32'h40, 32'h2001_0005, 1'b1, 5);
    fetch(32'h80, 32'h1234_5678, 1'b1, 5);
    fetch(32'h104, 32'hCAFE_0104, 1'b1, 5);
    fetch(32'h80, 32'h1234_5678, 1'b0, 0);
    fetch(32'h104, 32'hCAFE_0104, 1'b0, 0);
    @(posedge CLK);
    #1;
    imemREN = 1'b0;
    @(negedge CLK);
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, 32'd5);
    chk("miss_count", miss_count, 32'd3);
`endif
    chk("hitq_empty", 32'(hitq.size()), 32'd0);
    chk("fillq_empty", 32'(fillq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
